// File: rtl/mpmc12_cache_load_agen_if.sv
// Bus between the read-data return path / fill requester and the cache load address generator.
// The slave modport is the generator's view; the master modport is the requester/return path.
interface mpmc12_cache_load_agen_if #(
  parameter int unsigned AW  = 32,
  parameter int unsigned SW  = 6,
  parameter int unsigned CHW = 3,
  parameter int unsigned XCW = 8
);
  logic           start;
  logic           ready;
  logic           abort;
  logic [AW-1:0]  base_addr;
  logic [SW-1:0]  num_strips;
  logic [CHW-1:0] chan_in;
  logic           wrap;
  logic           valid;
  logic           wr_en;
  logic [AW-1:0]  addr;
  logic [CHW-1:0] chan;
  logic           last;
  logic           done;
  logic [XCW-1:0] stray_cnt;

  modport slave (
    input  start, abort, base_addr, num_strips, chan_in, wrap, valid,
    output ready, wr_en, addr, chan, last, done, stray_cnt
  );

  modport master (
    output start, abort, base_addr, num_strips, chan_in, wrap, valid,
    input  ready, wr_en, addr, chan, last, done, stray_cnt
  );
endinterface

// File: rtl/mpmc12_cache_load_agen.sv
// Cache load (line-fill) write address generator for the mpmc12 controller.
// Latches an aligned base, beat count and channel on start, then steps one strip per
// accepted read-data beat. Beats arriving outside a fill are dropped and counted.
// Optional feature: define MPMC12_WRAP_BURST_EN to enable critical-strip-first wrapping
// bursts (wrap=1 with a power-of-two length); otherwise every burst is linear.
module mpmc12_cache_load_agen #(
  parameter int unsigned AW         = 32,
  parameter int unsigned LOG2_STRIP = 5,
  parameter int unsigned SW         = 6,
  parameter int unsigned CHW        = 3,
  parameter int unsigned XCW        = 8
) (
  input logic                     clk,
  input logic                     rst,
  mpmc12_cache_load_agen_if.slave bus
);

  // Width of the strip index (address bits above the strip offset).
  localparam int unsigned IW = AW - LOG2_STRIP;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CHW-1:0] chan_q, chan_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  num_q, num_d;
  logic [XCW-1:0] stray_q, stray_d;

  logic [IW-1:0]  idx_cur;
  logic [IW-1:0]  idx_inc;
  logic [IW-1:0]  idx_next;
  logic [IW-1:0]  step_mask;
  logic [IW-1:0]  start_mask;
  logic           is_last;

`ifdef MPMC12_WRAP_BURST_EN
  // Index bits allowed to count; the rest are held so the burst wraps inside its block.
  logic [IW-1:0] mask_q, mask_d;
  logic [SW:0]   burst_len;
  logic          len_pow2;

  // Wrapping applies only to power-of-two lengths; num_strips is then exactly the index mask.
  always_comb begin
    burst_len  = {1'b0, bus.num_strips} + (SW+1)'(1);
    len_pow2   = (burst_len & (burst_len - (SW+1)'(1))) == '0;
    start_mask = (bus.wrap && len_pow2) ? IW'(bus.num_strips) : '1;
  end

  assign step_mask = mask_q;
`else
  assign start_mask = '1;
  assign step_mask  = '1;
`endif

  // Next strip index: masked bits increment, unmasked bits stay put.
  always_comb begin
    idx_cur  = addr_q[AW-1:LOG2_STRIP];
    idx_inc  = idx_cur + IW'(1);
    idx_next = (idx_cur & ~step_mask) | (idx_inc & step_mask);
  end

  assign is_last       = (cnt_q == num_q);
  assign bus.ready     = (state_q == StIdle);
  assign bus.wr_en     = bus.valid && (state_q == StLoad);
  assign bus.last      = bus.wr_en && is_last;
  assign bus.done      = (state_q == StDone);
  assign bus.addr      = addr_q;
  assign bus.chan      = chan_q;
  assign bus.stray_cnt = stray_q;

  // Next-state logic for the fill FSM, address stepping and stray-beat counter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    stray_d = stray_q;
`ifdef MPMC12_WRAP_BURST_EN
    mask_d  = mask_q;
`endif

    unique case (state_q)
      StIdle: begin
        // abort alongside start suppresses the start.
        if (bus.start && !bus.abort) begin
          state_d = StLoad;
          addr_d  = {bus.base_addr[AW-1:LOG2_STRIP], {LOG2_STRIP{1'b0}}};
          num_d   = bus.num_strips;
          chan_d  = bus.chan_in;
          cnt_d   = '0;
`ifdef MPMC12_WRAP_BURST_EN
          mask_d  = start_mask;
`endif
        end
      end
      StLoad: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.valid) begin
          if (is_last) begin
            // Address stays on the final strip.
            state_d = StDone;
          end else begin
            addr_d = {idx_next, {LOG2_STRIP{1'b0}}};
            cnt_d  = cnt_q + SW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (bus.valid && (state_q != StLoad) && (stray_q != '1)) begin
      stray_d = stray_q + XCW'(1);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '1;
      chan_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      stray_q <= '0;
`ifdef MPMC12_WRAP_BURST_EN
      mask_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      stray_q <= stray_d;
`ifdef MPMC12_WRAP_BURST_EN
      mask_q  <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_mpmc12_cache_load_agen.sv
// Self-checking bench for mpmc12_cache_load_agen: directed scenarios plus randomized fills
// checked against an arithmetic model of the fill address sequence.
module tb_mpmc12_cache_load_agen;
  localparam int unsigned AW  = 32;
  localparam int unsigned L2S = 5;
  localparam int unsigned SW  = 6;
  localparam int unsigned CHW = 3;
  localparam int unsigned XCW = 8;
  localparam int unsigned STRAY_MAX = (1 << XCW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mpmc12_cache_load_agen_if #(.AW(AW), .SW(SW), .CHW(CHW), .XCW(XCW)) bus ();

  mpmc12_cache_load_agen #(
    .AW(AW), .LOG2_STRIP(L2S), .SW(SW), .CHW(CHW), .XCW(XCW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned stray_exp = 0;
  logic [AW-1:0] addr_idle_exp = '1;

  // Address of beat k: strip index counts up from the base strip, modulo the index space,
  // or modulo the burst length inside its aligned block for enabled wrapping bursts.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int unsigned ns,
                                                input bit wrapbit, input int unsigned k);
    longint unsigned idx0 = longint'(base) >> L2S;
    longint unsigned len  = longint'(ns) + 1;
    longint unsigned span = 64'd1 << (AW - L2S);
    longint unsigned idx;
    bit wr = 1'b0;
`ifdef MPMC12_WRAP_BURST_EN
    wr = wrapbit && ((len & (len - 1)) == 0);
`else
    wr = wrapbit && 1'b0;
`endif
    if (wr) idx = (idx0 / len) * len + ((idx0 % len + longint'(k)) % len);
    else    idx = (idx0 + longint'(k)) % span;
    return AW'(idx << L2S);
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.valid = 1'b0; bus.wrap = 1'b0;
    bus.base_addr = '0; bus.num_strips = '0; bus.chan_in = '0;
  endtask

  // One fill. pat_len>0 uses pat bits as the valid sequence, else random gaps of gap_pct.
  // poke drives a conflicting start after the first accepted beat.
  task automatic run_fill(input logic [AW-1:0] base, input int unsigned ns,
                          input logic [CHW-1:0] ch, input bit wrapbit, input int unsigned gap_pct,
                          input logic [15:0] pat, input int unsigned pat_len, input bit poke,
                          input string tag);
    int unsigned k = 0;
    int unsigned cyc = 0;
    logic [AW-1:0] ea;
    vectors++;
    if (bus.ready !== 1'b1) begin
      miscompares++; $display("FAIL %s ready_before_start: got %b want 1", tag, bus.ready);
    end
    bus.start = 1'b1; bus.base_addr = base; bus.num_strips = SW'(ns);
    bus.chan_in = ch; bus.wrap = wrapbit;
    @(negedge clk);
    bus.start = 1'b0; bus.base_addr = $urandom; bus.num_strips = SW'($urandom);
    bus.chan_in = CHW'($urandom); bus.wrap = 1'($urandom);
    while (k <= ns && cyc < 2000) begin
      bus.valid = (pat_len > 0) ? pat[cyc % pat_len] : ($urandom_range(99) >= gap_pct);
      if (poke && k == 1) bus.start = 1'b1;
      #1;
      vectors++;
      if (bus.ready !== 1'b0) begin
        miscompares++; $display("FAIL %s ready_in_load: got %b want 0", tag, bus.ready);
      end
      if (bus.valid) begin
        ea = model_addr(base, ns, wrapbit, k);
        vectors += 4;
        if (bus.wr_en !== 1'b1) begin
          miscompares++; $display("FAIL %s wr_en beat%0d: got %b want 1", tag, k, bus.wr_en);
        end
        if (bus.addr !== ea) begin
          miscompares++; $display("FAIL %s addr beat%0d: got %h want %h", tag, k, bus.addr, ea);
        end
        if (bus.chan !== ch) begin
          miscompares++; $display("FAIL %s chan beat%0d: got %0d want %0d", tag, k, bus.chan, ch);
        end
        if (bus.last !== (k == ns)) begin
          miscompares++;
          $display("FAIL %s last beat%0d: got %b want %b", tag, k, bus.last, (k == ns));
        end
        k++;
      end else begin
        vectors++;
        if (bus.wr_en !== 1'b0 || bus.last !== 1'b0) begin
          miscompares++;
          $display("FAIL %s gap_wr_en: got %b/%b want 0/0", tag, bus.wr_en, bus.last);
        end
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    if (k <= ns) begin
      miscompares++; $display("FAIL %s beat_budget: got %0d beats want %0d", tag, k, ns + 1);
    end
    bus.valid = 1'b0;
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b0 || bus.wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_cycle: got done=%b ready=%b wr_en=%b want 1/0/0", tag, bus.done,
               bus.ready, bus.wr_en);
    end
    @(negedge clk); #1;
    addr_idle_exp = model_addr(base, ns, wrapbit, ns);
    vectors += 2;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s after_done: got done=%b ready=%b want 0/1", tag, bus.done, bus.ready);
    end
    if (bus.addr !== addr_idle_exp || bus.chan !== ch) begin
      miscompares++;
      $display("FAIL %s hold_after_fill: got %h/%0d want %h/%0d", tag, bus.addr, bus.chan,
               addr_idle_exp, ch);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    stray_exp = 0;
    addr_idle_exp = '1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.addr !== {AW{1'b1}} || bus.chan !== '0 || bus.done !== 1'b0 ||
        bus.wr_en !== 1'b0 || bus.last !== 1'b0 || bus.stray_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset: got ready=%b addr=%h chan=%0d done=%b wr_en=%b last=%b stray=%0d want 1/ffffffff/0/0/0/0/0",
               bus.ready, bus.addr, bus.chan, bus.done, bus.wr_en, bus.last, bus.stray_cnt);
    end
  endtask

  task automatic test_basic();
    run_fill(32'h1234_5678, 3, 3'd2, 1'b0, 0, 16'h0, 0, 1'b0, "basic");
    vectors++;
    if (addr_idle_exp !== 32'h1234_56C0 || bus.addr !== 32'h1234_56C0) begin
      miscompares++; $display("FAIL basic_final_addr: got %h want 123456c0", bus.addr);
    end
  endtask

  task automatic test_gapped();
    run_fill(32'h0000_2000, 3, 3'd6, 1'b0, 0, 16'b1011001, 7, 1'b0, "gapped");
  endtask

  task automatic stray_beats(input int unsigned n, input string tag);
    for (int i = 0; i < int'(n); i++) begin
      bus.valid = 1'b1;
      #1;
      vectors++;
      if (bus.wr_en !== 1'b0 || bus.addr !== addr_idle_exp) begin
        miscompares++;
        $display("FAIL %s stray_beat%0d: got wr_en=%b addr=%h want 0/%h", tag, i, bus.wr_en,
                 bus.addr, addr_idle_exp);
      end
      @(negedge clk);
      if (stray_exp < STRAY_MAX) stray_exp++;
    end
    bus.valid = 1'b0;
    #1;
    vectors++;
    if (bus.stray_cnt !== XCW'(stray_exp)) begin
      miscompares++; $display("FAIL %s stray_cnt: got %0d want %0d", tag, bus.stray_cnt, stray_exp);
    end
  endtask

  task automatic test_stray();
    stray_beats(3, "stray_idle");
    run_fill(32'h0000_4000, 1, 3'd1, 1'b0, 30, 16'h0, 0, 1'b0, "stray_fill");
    stray_beats(2, "stray_after");
    vectors++;
    if (bus.stray_cnt !== XCW'(5)) begin
      miscompares++; $display("FAIL stray_five: got %0d want 5", bus.stray_cnt);
    end
    stray_beats(300, "stray_sat");
  endtask

  task automatic test_abort();
    logic [AW-1:0] b = 32'h0000_8000;
    bus.start = 1'b1; bus.base_addr = b; bus.num_strips = SW'(3); bus.chan_in = 3'd4;
    @(negedge clk);
    bus.start = 1'b0;
    bus.valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.valid = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_mid: got ready=%b done=%b want 1/0", bus.ready, bus.done);
    end
    // abort coincident with the final beat: beat written, no done pulse
    bus.start = 1'b1; bus.base_addr = 32'h0000_9000; bus.num_strips = '0; bus.chan_in = 3'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.valid = 1'b1; bus.abort = 1'b1;
    #1;
    vectors++;
    if (bus.wr_en !== 1'b1 || bus.last !== 1'b1 || bus.addr !== 32'h0000_9000) begin
      miscompares++;
      $display("FAIL abort_last_beat: got wr_en=%b last=%b addr=%h want 1/1/00009000",
               bus.wr_en, bus.last, bus.addr);
    end
    @(negedge clk);
    bus.valid = 1'b0; bus.abort = 1'b0;
    #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_last_no_done: got done=%b ready=%b want 0/1", bus.done, bus.ready);
    end
    // abort with start in idle: start dropped
    bus.start = 1'b1; bus.abort = 1'b1; bus.base_addr = 32'h0000_A000;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    #1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.addr !== 32'h0000_9000) begin
      miscompares++;
      $display("FAIL abort_start_idle: got ready=%b addr=%h want 1/00009000", bus.ready, bus.addr);
    end
    run_fill(32'h0000_0100, 1, 3'd0, 1'b0, 0, 16'h0, 0, 1'b0, "after_abort");
  endtask

  task automatic test_start_in_load();
    run_fill(32'h0000_C000, 3, 3'd5, 1'b0, 20, 16'h0, 0, 1'b1, "start_in_load");
  endtask

  task automatic test_rst_mid_fill();
    bus.start = 1'b1; bus.base_addr = 32'h0000_D000; bus.num_strips = SW'(5); bus.chan_in = 3'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    stray_exp = 0;
    addr_idle_exp = '1;
    vectors++;
    if (bus.addr !== {AW{1'b1}} || bus.ready !== 1'b1 || bus.chan !== '0 ||
        bus.stray_cnt !== '0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_fill: got addr=%h ready=%b chan=%0d stray=%0d done=%b want ffffffff/1/0/0/0",
               bus.addr, bus.ready, bus.chan, bus.stray_cnt, bus.done);
    end
    stray_beats(1, "rst_then_beat");
  endtask

  task automatic test_boundary();
    run_fill(32'hFFFF_FFDF, 3, 3'd1, 1'b0, 0, 16'h0, 0, 1'b0, "top_wrap");
    run_fill(32'h0000_0040, 0, 3'd2, 1'b0, 0, 16'h0, 0, 1'b0, "single_beat");
    run_fill(32'h0001_0000, (1 << SW) - 1, 3'd3, 1'b0, 10, 16'h0, 0, 1'b0, "max_burst");
  endtask

  task automatic test_wrap();
    run_fill(32'h0000_1040, 3, 3'd1, 1'b1, 0, 16'h0, 0, 1'b0, "wrap_pow2");
`ifdef MPMC12_WRAP_BURST_EN
    vectors++;
    if (bus.addr !== 32'h0000_1020) begin
      miscompares++; $display("FAIL wrap_pow2_final: got %h want 00001020", bus.addr);
    end
`else
    vectors++;
    if (bus.addr !== 32'h0000_10A0) begin
      miscompares++; $display("FAIL wrap_ignored_final: got %h want 000010a0", bus.addr);
    end
`endif
    run_fill(32'h0000_1040, 2, 3'd1, 1'b1, 0, 16'h0, 0, 1'b0, "wrap_npow2");
    vectors++;
    if (bus.addr !== 32'h0000_1080) begin
      miscompares++; $display("FAIL wrap_npow2_final: got %h want 00001080", bus.addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [AW-1:0] b = $urandom;
      int unsigned ns = ($urandom_range(3) == 0) ? $urandom_range((1 << SW) - 1) : $urandom_range(7);
      run_fill(b, ns, CHW'($urandom), 1'($urandom), $urandom_range(50), 16'h0, 0, 1'b0, "random");
      if ($urandom_range(3) == 0) stray_beats($urandom_range(1, 3), "random_stray");
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_gapped();
    test_stray();
    test_abort();
    test_start_in_load();
    test_rst_mid_fill();
    test_boundary();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
